// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS mnemonics into a word FIFO and streams them to instruction memory.
// Optional NOP padding after beq/j is enabled by defining INSTR_ENCODER_NOP_PAD_EN.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int PAD_NOPS = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              end_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        op_sel_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic              mem_we_o,
  input  logic              mem_ready_i,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic [ADDR_W-1:0] word_cnt_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef INSTR_ENCODER_NOP_PAD_EN
  localparam int W = 33;
`else
  localparam int W = 32 + 0 * PAD_NOPS;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [W-1:0] fifo [FIFO_DEPTH];
  logic [W-1:0] head, entry;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [31:0] word;
  logic legal, fire, push, pop, wr, empty, pad;
  always_comb begin
    word = 32'h0;
    legal = 1'b1;
    case (op_sel_i)
      4'd0:  word = {6'h00, rs_i, rt_i, rd_i, 5'h0, 6'h20};
      4'd1:  word = {6'h00, rs_i, rt_i, rd_i, 5'h0, 6'h22};
      4'd2:  word = {6'h00, rs_i, rt_i, rd_i, 5'h0, 6'h24};
      4'd3:  word = {6'h00, rs_i, rt_i, rd_i, 5'h0, 6'h25};
      4'd4:  word = {6'h00, rs_i, rt_i, rd_i, 5'h0, 6'h2a};
      4'd5:  word = {6'h08, rs_i, rt_i, imm_i};
      4'd6:  word = {6'h0a, rs_i, rt_i, imm_i};
      4'd7:  word = {6'h04, rs_i, rt_i, imm_i};
      4'd8:  word = {6'h0f, 5'h0, rt_i, imm_i};
      4'd9:  word = {6'h0d, rs_i, rt_i, imm_i};
      4'd10: word = {6'h23, rs_i, rt_i, imm_i};
      4'd11: word = {6'h2b, rs_i, rt_i, imm_i};
      4'd12: word = {6'h02, target_i};
      default: legal = 1'b0;
    endcase
  end
  assign empty = count == '0;
  assign head = fifo[rd_ptr];
  assign busy_o = state == RUN || state == DRAIN;
  assign done_o = state == DONE;
  assign req_ready_o = state == RUN && count != (PW+1)'(FIFO_DEPTH);
  assign fire = req_valid_i & req_ready_o;
  assign push = fire & legal;
  assign mem_addr_o = BASE_ADDR + 32'({word_cnt_o, 2'b00});
  assign wr = mem_we_o & mem_ready_i;
`ifdef INSTR_ENCODER_NOP_PAD_EN
  logic [7:0] pad_cnt;
  assign entry = {op_sel_i == 4'd7 || op_sel_i == 4'd12, word};
  assign pad = pad_cnt != 8'd0;
  assign mem_we_o = busy_o & (pad | ~empty);
  assign mem_data_o = (mem_we_o & ~pad) ? head[31:0] : 32'h0;
  assign pop = wr & ~pad;
  // The flagged word leaves the FIFO when written; its NOPs follow from the counter.
  always_ff @(posedge clk_i)
    if (rst_i) pad_cnt <= 8'd0;
    else if (pop & head[32]) pad_cnt <= 8'(PAD_NOPS);
    else if (wr & pad) pad_cnt <= pad_cnt - 8'd1;
`else
  assign entry = word;
  assign pad = 1'b0;
  assign mem_we_o = busy_o & ~empty;
  assign mem_data_o = mem_we_o ? head : 32'h0;
  assign pop = wr;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      word_cnt_o <= '0;
      ovf_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      err_o <= fire & ~legal;
      if (push) begin
        fifo[wr_ptr] <= entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (wr) begin
        word_cnt_o <= word_cnt_o + 1'b1;
        if (&word_cnt_o) ovf_o <= 1'b1;
      end
      case (state)
        IDLE, DONE: if (start_i) begin
          state <= RUN;
          word_cnt_o <= '0;
          ovf_o <= 1'b0;
        end
        RUN: if (end_i) state <= DRAIN;
        default: if (empty & ~pad) state <= DONE;
      endcase
    end
  end
endmodule
